// File: rtl/mem_arbiter_pkg.sv
// Shared SoC definitions for the memory arbiter: default bus widths and the
// registered owner-state enumeration that tracks who used the RAM last cycle.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_CPU_WR = 2'd2,
    OWN_VID_RD = 2'd3
  } owner_e;

  // Translate this cycle's grant into the owner recorded for the next cycle.
  function automatic owner_e owner_from_grant(input logic cpu_gnt,
                                              input logic cpu_we,
                                              input logic vid_gnt);
    owner_e own;
    own = OWN_NONE;
    if (cpu_gnt)      own = cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
    else if (vid_gnt) own = OWN_VID_RD;
    return own;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve.sv
// Starvation guard for the CPU port: counts consecutive cycles in which the
// CPU asks for the RAM and is refused, and raises force_cpu once the count
// reaches STARVE_MAX so the next conflict goes to the CPU.
module mem_arb_starve #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic cpu_gnt,
  output logic force_cpu
);

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  logic [3:0] r_starve_cnt;

  assign force_cpu = (r_starve_cnt == MAX_C);

  // Saturating denial counter; any grant or dropped request restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (cpu_req && !cpu_gnt) begin
      if (r_starve_cnt != MAX_C) r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between a CPU and a video fetch unit.
// Video wins conflicts unless the CPU has been refused STARVE_MAX times in
// a row. Read data returns one cycle after the grant and is steered to the
// requester recorded in the owner register.
// Optional build macro: MEM_ARB_STATS_EN adds the cpu_stall_cnt output.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0]       cpu_stall_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  logic   w_force_cpu;
  logic   w_cpu_gnt;
  logic   w_vid_gnt;
  owner_e r_owner;

  mem_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_gnt   (w_cpu_gnt),
    .force_cpu (w_force_cpu)
  );

  // Grant decision: the CPU takes the RAM when alone or when starved;
  // reset masks both grants so nothing reaches the RAM while it is held.
  always_comb begin
    w_cpu_gnt = !rst && cpu_req && (!vid_req || w_force_cpu);
    w_vid_gnt = !rst && vid_req && !w_cpu_gnt;
  end

  // RAM port mux: the winner drives address and data, idle cycles drive 0.
  always_comb begin
    mem_en    = w_cpu_gnt | w_vid_gnt;
    mem_we    = w_cpu_gnt & cpu_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_vid_gnt) begin
      mem_addr  = vid_addr;
    end
  end

  assign cpu_gnt = w_cpu_gnt;
  assign vid_gnt = w_vid_gnt;

  // Remember who used the RAM so the returning read data can be steered;
  // the async clear also drops any read that was in flight at reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_owner <= OWN_NONE;
    else     r_owner <= owner_from_grant(w_cpu_gnt, cpu_we, w_vid_gnt);
  end

  assign cpu_rvalid = (r_owner == OWN_CPU_RD);
  assign vid_rvalid = (r_owner == OWN_VID_RD);
  assign cpu_rdata  = mem_rdata;
  assign vid_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  // Count cycles the CPU waited, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_stall_cnt <= 16'd0;
    else if (cpu_req && !w_cpu_gnt && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign cpu_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// random phase, all compared against a cycle-level reference model.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_addr, vid_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid;
  logic [DW-1:0] cpu_rdata, vid_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   cpu_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_STATS_EN
    .cpu_stall_cnt(cpu_stall_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  // Behavioural RAM: registered read, loaded from the shadow image at start.
  logic [DW-1:0] ram    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic          tb_init;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= shadow[i];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state
  int            checks = 0;
  int            errors = 0;
  int            denials;        // consecutive CPU refusals
  int            stalls;         // cycles CPU waited since reset
  bit            pend_cpu, pend_vid;
  logic [DW-1:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    denials  = 0;
    stalls   = 0;
    pend_cpu = 0;
    pend_vid = 0;
  endtask

  // One bus cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                       input logic [DW-1:0] cwd, input bit vreq, input logic [AW-1:0] vaddr);
    bit            e_cg, e_vg;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vid_req = vreq; vid_addr = vaddr;
    #3;
    e_cg   = creq && (!vreq || denials >= SMAX);
    e_vg   = vreq && !e_cg;
    e_addr = e_cg ? caddr : (e_vg ? vaddr : '0);
    e_wd   = e_cg ? cwd : '0;
    $display("t=%0t cpu_req=%0b we=%0b a=%03h vid_req=%0b a=%03h -> cgnt=%0b vgnt=%0b crv=%0b vrv=%0b",
             $time, creq, cwe, caddr, vreq, vaddr, cpu_gnt, vid_gnt, cpu_rvalid, vid_rvalid);
    chk("cpu_gnt",    cpu_gnt,    e_cg);
    chk("vid_gnt",    vid_gnt,    e_vg);
    chk("mem_en",     mem_en,     e_cg | e_vg);
    chk("mem_we",     mem_we,     e_cg & cwe);
    chk("mem_addr",   mem_addr,   e_addr);
    chk("mem_wdata",  mem_wdata,  e_wd);
    chk("cpu_rvalid", cpu_rvalid, pend_cpu);
    chk("vid_rvalid", vid_rvalid, pend_vid);
    if (pend_cpu) chk("cpu_rdata", cpu_rdata, pend_data);
    if (pend_vid) chk("vid_rdata", vid_rdata, pend_data);
`ifdef MEM_ARB_STATS_EN
    chk("stall_cnt", cpu_stall_cnt, stalls);
`endif
    @(posedge clk);
    pend_cpu = e_cg && !cwe;
    pend_vid = e_vg;
    if (e_cg || e_vg) pend_data = shadow[e_addr];
    if (e_cg && cwe) shadow[caddr] = cwd;
    if (creq && !e_cg) begin
      if (denials < SMAX) denials++;
      if (stalls < 16'hFFFF) stalls++;
    end else begin
      denials = 0;
    end
    #1;
  endtask

  // Assert reset mid-cycle (optionally with requests active) and check that
  // everything is quiet, then release it between edges.
  task automatic do_reset(input bit hold_reqs);
    rst = 1'b1; cpu_req = hold_reqs; vid_req = hold_reqs; cpu_we = 1'b0;
    #3;
    $display("t=%0t reset asserted, reqs=%0b", $time, hold_reqs);
    chk("rst_cpu_gnt",    cpu_gnt,    1'b0);
    chk("rst_vid_gnt",    vid_gnt,    1'b0);
    chk("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    chk("rst_vid_rvalid", vid_rvalid, 1'b0);
    chk("rst_mem_en",     mem_en,     1'b0);
    chk("rst_mem_we",     mem_we,     1'b0);
    chk("rst_mem_addr",   mem_addr,   '0);
`ifdef MEM_ARB_STATS_EN
    chk("rst_stall_cnt",  cpu_stall_cnt, 16'd0);
`endif
    @(posedge clk);
    #2;
    cpu_req = 1'b0; vid_req = 1'b0;
    rst = 1'b0; tb_init = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            hold;
    bit            c_req, c_we, v_req;
    logic [AW-1:0] c_addr, v_addr;
    logic [DW-1:0] c_wd;

    rst = 1'b1; tb_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'($urandom);
    model_reset();
    @(posedge clk); #1;
    do_reset(1'b1);

    // CPU read of 0x010 alone, then idle to see the data return
    cycle(1, 0, 12'h010, 8'h00, 0, '0);
    cycle(0, 0, '0, 8'h00, 0, '0);

    // CPU write 0x55 to 0x020, then read it back
    cycle(1, 1, 12'h020, 8'h55, 0, '0);
    cycle(0, 0, '0, 8'h00, 0, '0);
    cycle(1, 0, 12'h020, 8'h00, 0, '0);
    cycle(0, 0, '0, 8'h00, 0, '0);
    chk("readback_55", shadow[12'h020], 8'h55);

    // Continuous conflict: V,V,V,V,C repeating
    for (int i = 0; i < 15; i++) cycle(1, 0, 12'h030, 8'h00, 1, 12'h100 + 12'(i));
    cycle(0, 0, '0, 8'h00, 0, '0);

    // Alternating single-requester reads
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cycle(1, 0, 12'h040 + 12'(i), 8'h00, 0, '0);
      else            cycle(0, 0, '0, 8'h00, 1, 12'h200 + 12'(i));
    end
    cycle(0, 0, '0, 8'h00, 0, '0);

    // Reset in the cycle after a CPU read grant; first conflict after goes to video
    cycle(1, 0, 12'h010, 8'h00, 0, '0);
    do_reset(1'b1);
    cycle(1, 0, 12'h011, 8'h00, 1, 12'h300);
    cycle(0, 0, '0, 8'h00, 0, '0);

    // Ten conflict cycles from reset
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 12'h050, 8'h00, 1, 12'h060);
`ifdef MEM_ARB_STATS_EN
    chk("stall_after_10", cpu_stall_cnt, 16'd8);
`endif
    cycle(0, 0, '0, 8'h00, 0, '0);

    // Random traffic; a refused CPU request is usually held unchanged
    c_req = 0; c_we = 0; c_addr = '0; c_wd = '0; v_req = 0; v_addr = '0;
    for (int n = 0; n < 300; n++) begin
      hold = c_req && !cpu_gnt && ($urandom_range(0, 9) != 0);
      if (!hold) begin
        c_req  = ($urandom_range(0, 2) != 0);
        c_we   = ($urandom_range(0, 2) == 0);
        c_addr = AW'($urandom_range(0, 31));
        c_wd   = DW'($urandom);
      end
      v_req  = ($urandom_range(0, 2) != 0);
      v_addr = AW'($urandom_range(0, 31));
      cycle(c_req, c_we, c_addr, c_wd, v_req, v_addr);
    end
    cycle(0, 0, '0, 8'h00, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
